m_div_sequencer: RTL and testbench

//  Issue-side sequencer for RV32M DIV/DIVU/REM/REMU. Takes one op from the execute stage via valid/ready,

---
 rtl/m_div_pkg.sv | 30 +++
 rtl/m_div_special.sv | 35 +++
 rtl/m_div_sequencer.sv | 172 +++++++++++++++++
 tb/tb_m_div_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_div_pkg.sv
// Shared definitions for the RV32M divide sequencer: funct encodings,
// FSM states and small decode helpers.
package m_div_pkg;

    // funct3[1:0] of the RV32M divide group
    typedef enum logic [1:0] {
        FUNCT_DIV  = 2'b00,
        FUNCT_DIVU = 2'b01,
        FUNCT_REM  = 2'b10,
        FUNCT_REMU = 2'b11
    } funct_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        WAIT   = 2'b10,
        DONE   = 2'b11
    } state_e;

    // DIV and REM treat operands as two's complement
    function automatic logic is_signed_op(input logic [1:0] funct);
        return (funct == FUNCT_DIV) || (funct == FUNCT_REM);
    endfunction

    // REM and REMU return the remainder rather than the quotient
    function automatic logic is_rem_op(input logic [1:0] funct);
        return (funct == FUNCT_REM) || (funct == FUNCT_REMU);
    endfunction

endpackage

// File: rtl/m_div_special.sv
// Detects the RISC-V divide corner cases that are answered without the
// iterative core: divide-by-zero and signed overflow (most negative / -1).
module m_div_special
    import m_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            is_signed,
    output logic            is_special,
    output logic [XLEN-1:0] special_quotient,
    output logic [XLEN-1:0] special_remainder
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Divide-by-zero takes priority over overflow (MOST_NEG / 0 is a div-by-zero)
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        is_special        = 1'b0;
        special_quotient  = '1;
        special_remainder = rs1;
        if (rs2 == '0) begin
            is_special        = 1'b1;
            special_quotient  = '1;
            special_remainder = rs1;
        end else if (is_signed && (rs1 == MOST_NEG) && (rs2 == '1)) begin
            is_special        = 1'b1;
            special_quotient  = rs1;
            special_remainder = '0;
        end
    end

endmodule

// File: rtl/m_div_sequencer.sv
// Issue-side sequencer for RV32M DIV/DIVU/REM/REMU. Accepts one op, answers
// corner cases and repeat operands in one cycle from a one-entry result
// cache, otherwise launches the external restoring divider and waits for it.
module m_div_sequencer
    import m_div_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 STALL,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [1:0]           FUNCT,
    input  logic [XLEN-1:0]      RS1,
    input  logic [XLEN-1:0]      RS2,
    input  logic [TAG_WIDTH-1:0] TAG_IN,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [XLEN-1:0]      RESULT,
    output logic [TAG_WIDTH-1:0] TAG_OUT,
    output logic                 BUSY,
    output logic                 DIV_START,
    output logic                 DIV_SIGN,
    output logic [XLEN-1:0]      DIV_DIVIDEND,
    output logic [XLEN-1:0]      DIV_DIVIDER,
    output logic                 DIV_STALL,
    input  logic [XLEN-1:0]      DIV_QUOTIENT,
    input  logic [XLEN-1:0]      DIV_REMAINDER,
    input  logic                 DIV_READY
);

    state_e                 state_q, state_d;
    logic [XLEN-1:0]        rs1_q, rs1_d;
    logic [XLEN-1:0]        rs2_q, rs2_d;
    logic [1:0]             funct_q, funct_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [XLEN-1:0]        result_q, result_d;

    // One-entry cache of the last core-computed division
    logic                   cache_valid_q, cache_valid_d;
    logic [XLEN-1:0]        cache_rs1_q, cache_rs1_d;
    logic [XLEN-1:0]        cache_rs2_q, cache_rs2_d;
    logic                   cache_signed_q, cache_signed_d;
    logic [XLEN-1:0]        cache_quot_q, cache_quot_d;
    logic [XLEN-1:0]        cache_rem_q, cache_rem_d;

    logic                   in_signed;
    logic                   cache_hit;
    logic                   is_special;
    logic [XLEN-1:0]        special_quotient;
    logic [XLEN-1:0]        special_remainder;

    assign in_signed = is_signed_op(FUNCT);
    assign cache_hit = cache_valid_q && (cache_rs1_q == RS1) && (cache_rs2_q == RS2)
                       && (cache_signed_q == in_signed);

    m_div_special #(
        .XLEN (XLEN)
    ) u_special (
        .rs1               (RS1),
        .rs2               (RS2),
        .is_signed         (in_signed),
        .is_special        (is_special),
        .special_quotient  (special_quotient),
        .special_remainder (special_remainder)
    );

    // Next-state, operand latch, result and cache update; STALL holds everything
    always_comb begin
        state_d        = state_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        funct_d        = funct_q;
        tag_d          = tag_q;
        result_d       = result_q;
        cache_valid_d  = cache_valid_q;
        cache_rs1_d    = cache_rs1_q;
        cache_rs2_d    = cache_rs2_q;
        cache_signed_d = cache_signed_q;
        cache_quot_d   = cache_quot_q;
        cache_rem_d    = cache_rem_q;
        if (!STALL) begin
            unique case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        rs1_d   = RS1;
                        rs2_d   = RS2;
                        funct_d = FUNCT;
                        tag_d   = TAG_IN;
                        if (is_special) begin
                            result_d = is_rem_op(FUNCT) ? special_remainder : special_quotient;
                            state_d  = DONE;
                        end else if (cache_hit) begin
                            result_d = is_rem_op(FUNCT) ? cache_rem_q : cache_quot_q;
                            state_d  = DONE;
                        end else begin
                            state_d = LAUNCH;
                        end
                    end
                end
                LAUNCH: state_d = WAIT;
                WAIT: begin
                    // Core READY drops on the START edge, so READY here means our result
                    if (DIV_READY) begin
                        result_d       = is_rem_op(funct_q) ? DIV_REMAINDER : DIV_QUOTIENT;
                        cache_valid_d  = 1'b1;
                        cache_rs1_d    = rs1_q;
                        cache_rs2_d    = rs2_q;
                        cache_signed_d = is_signed_op(funct_q);
                        cache_quot_d   = DIV_QUOTIENT;
                        cache_rem_d    = DIV_REMAINDER;
                        state_d        = DONE;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the cache payload is reset along with its valid bit; it is a
            // handful of flops, not a RAM, and a clean reset keeps RESULT at zero.
            state_q        <= IDLE;
            rs1_q          <= '0;
            rs2_q          <= '0;
            funct_q        <= '0;
            tag_q          <= '0;
            result_q       <= '0;
            cache_valid_q  <= 1'b0;
            cache_rs1_q    <= '0;
            cache_rs2_q    <= '0;
            cache_signed_q <= 1'b0;
            cache_quot_q   <= '0;
            cache_rem_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            funct_q        <= funct_d;
            tag_q          <= tag_d;
            result_q       <= result_d;
            cache_valid_q  <= cache_valid_d;
            cache_rs1_q    <= cache_rs1_d;
            cache_rs2_q    <= cache_rs2_d;
            cache_signed_q <= cache_signed_d;
            cache_quot_q   <= cache_quot_d;
            cache_rem_q    <= cache_rem_d;
        end
    end

    assign IN_READY     = (state_q == IDLE) && !STALL;
    assign OUT_VALID    = (state_q == DONE);
    assign BUSY         = (state_q != IDLE);
    assign DIV_START    = (state_q == LAUNCH);
    assign DIV_SIGN     = is_signed_op(funct_q);
    assign DIV_DIVIDEND = rs1_q;
    assign DIV_DIVIDER  = rs2_q;
    assign DIV_STALL    = STALL;
    assign RESULT       = result_q;
    assign TAG_OUT      = tag_q;

endmodule

// File: tb/tb_m_div_sequencer.sv
// Self-checking bench for m_div_sequencer paired with a behavioural model of
// the iterative divider core (READY low for XLEN cycles after START).
module tb_m_div_sequencer;
    import m_div_pkg::*;

    localparam int XLEN      = 32;
    localparam int TAG_WIDTH = 5;
    localparam int SLOW      = XLEN + 2;
    localparam int MAX_WAIT  = 200;
    localparam int NVEC      = 13;

    logic                 CLK       = 1'b0;
    logic                 RST       = 1'b1;
    logic                 STALL     = 1'b0;
    logic                 IN_VALID  = 1'b0;
    logic                 OUT_READY = 1'b1;
    logic [1:0]           FUNCT     = 2'b00;
    logic [XLEN-1:0]      RS1       = '0;
    logic [XLEN-1:0]      RS2       = '0;
    logic [TAG_WIDTH-1:0] TAG_IN    = '0;

    logic                 IN_READY, OUT_VALID, BUSY, DIV_START, DIV_SIGN, DIV_STALL;
    logic [XLEN-1:0]      RESULT, DIV_DIVIDEND, DIV_DIVIDER;
    logic [TAG_WIDTH-1:0] TAG_OUT;

    logic [XLEN-1:0]      DIV_QUOTIENT  = '0;
    logic [XLEN-1:0]      DIV_REMAINDER = '0;
    logic                 DIV_READY     = 1'b1;
    int                   core_cnt      = 0;

    int n_checks  = 0;
    int n_errors  = 0;
    int start_cnt = 0;

    typedef struct {
        logic [XLEN-1:0]      result;
        logic [TAG_WIDTH-1:0] tag;
    } exp_t;

    typedef struct {
        logic [1:0]           funct;
        logic [XLEN-1:0]      rs1;
        logic [XLEN-1:0]      rs2;
        logic [TAG_WIDTH-1:0] tag;
        logic [XLEN-1:0]      result;
        int                   lat;
        int                   starts;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[NVEC];

    always #5 CLK = ~CLK;

    m_div_sequencer #(
        .XLEN      (XLEN),
        .TAG_WIDTH (TAG_WIDTH)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .STALL         (STALL),
        .IN_VALID      (IN_VALID),
        .IN_READY      (IN_READY),
        .FUNCT         (FUNCT),
        .RS1           (RS1),
        .RS2           (RS2),
        .TAG_IN        (TAG_IN),
        .OUT_VALID     (OUT_VALID),
        .OUT_READY     (OUT_READY),
        .RESULT        (RESULT),
        .TAG_OUT       (TAG_OUT),
        .BUSY          (BUSY),
        .DIV_START     (DIV_START),
        .DIV_SIGN      (DIV_SIGN),
        .DIV_DIVIDEND  (DIV_DIVIDEND),
        .DIV_DIVIDER   (DIV_DIVIDER),
        .DIV_STALL     (DIV_STALL),
        .DIV_QUOTIENT  (DIV_QUOTIENT),
        .DIV_REMAINDER (DIV_REMAINDER),
        .DIV_READY     (DIV_READY)
    );

    // Divider core model: not reset, frozen by DIV_STALL, restarted by START
    always @(posedge CLK) begin
        if (!DIV_STALL) begin
            if (DIV_START) begin
                DIV_READY <= 1'b0;
                core_cnt  <= XLEN;
                if (DIV_SIGN) begin
                    DIV_QUOTIENT  <= $signed(DIV_DIVIDEND) / $signed(DIV_DIVIDER);
                    DIV_REMAINDER <= $signed(DIV_DIVIDEND) % $signed(DIV_DIVIDER);
                end else begin
                    DIV_QUOTIENT  <= DIV_DIVIDEND / DIV_DIVIDER;
                    DIV_REMAINDER <= DIV_DIVIDEND % DIV_DIVIDER;
                end
            end else if (core_cnt > 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1) DIV_READY <= 1'b1;
            end
        end
    end

    // Count START pulses the core actually sees
    always @(posedge CLK) begin
        if (DIV_START && !STALL) start_cnt++;
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one op, measure edges from acceptance to OUT_VALID, optionally stall
    // the pipeline for st_len cycles starting st_at edges after acceptance and
    // hold OUT_READY low for 'hold' cycles, then pop the scoreboard on handshake.
    task automatic run_op(input string name, input logic [1:0] f,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [TAG_WIDTH-1:0] t, input logic [XLEN-1:0] exp_res,
                          input int exp_lat, input int exp_starts,
                          input int st_at, input int st_len, input int hold);
        int                   lat;
        int                   s0;
        int                   guard;
        logic                 ok_ready;
        logic                 ok_stall;
        logic                 ok_hold;
        logic [XLEN-1:0]      held_res;
        logic [TAG_WIDTH-1:0] held_tag;
        exp_t                 e;

        sb_q.push_back('{result: exp_res, tag: t});
        @(negedge CLK);
        guard = 0;
        while (!IN_READY && guard < MAX_WAIT) begin
            @(negedge CLK);
            guard++;
        end
        check({name, " in_ready_idle"}, 32'(IN_READY), 32'd1);

        IN_VALID  = 1'b1;
        FUNCT     = f;
        RS1       = a;
        RS2       = b;
        TAG_IN    = t;
        OUT_READY = (hold == 0);
        s0        = start_cnt;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        RS1      = $urandom();
        RS2      = $urandom();
        FUNCT    = 2'($urandom());
        TAG_IN   = TAG_WIDTH'($urandom());

        lat      = 0;
        ok_ready = 1'b1;
        ok_stall = 1'b1;
        while (!OUT_VALID && lat < MAX_WAIT) begin
            STALL = (st_len > 0) && (lat >= st_at) && (lat < st_at + st_len);
            #1;
            if (DIV_STALL !== STALL) ok_stall = 1'b0;
            if (IN_READY) ok_ready = 1'b0;
            @(posedge CLK);
            #1;
            lat++;
        end
        STALL = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " start_pulses"}, 32'(start_cnt - s0), 32'(exp_starts));

        ok_hold  = 1'b1;
        held_res = RESULT;
        held_tag = TAG_OUT;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK);
            #1;
            if (!OUT_VALID || RESULT !== held_res || TAG_OUT !== held_tag) ok_hold = 1'b0;
            if (IN_READY) ok_ready = 1'b0;
        end
        if (hold > 0) check({name, " held_in_done"}, 32'(ok_hold), 32'd1);
        if (st_len > 0) check({name, " div_stall_follows"}, 32'(ok_stall), 32'd1);
        check({name, " in_ready_low_busy"}, 32'(ok_ready), 32'd1);
        OUT_READY = 1'b1;

        check({name, " out_valid"}, 32'(OUT_VALID), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({name, " result"}, RESULT, e.result);
            check({name, " tag"}, 32'(TAG_OUT), 32'(e.tag));
        end else begin
            check({name, " scoreboard_empty"}, 32'(sb_q.size()), 32'd1);
        end
        @(posedge CLK);
        #1;
        check({name, " idle_after"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        //            funct       rs1           rs2           tag    result        lat   starts
        vecs[0]  = '{FUNCT_DIVU, 32'd100,      32'd7,        5'd1,  32'd14,       SLOW, 1};
        vecs[1]  = '{FUNCT_REMU, 32'd100,      32'd7,        5'd2,  32'd2,        0,    0};
        vecs[2]  = '{FUNCT_DIV,  32'hFFFFFF9C, 32'd7,        5'd3,  32'hFFFFFFF2, SLOW, 1};
        vecs[3]  = '{FUNCT_REM,  32'hFFFFFF9C, 32'd7,        5'd4,  32'hFFFFFFFE, 0,    0};
        vecs[4]  = '{FUNCT_DIVU, 32'hFFFFFF9C, 32'd7,        5'd5,  32'h24924916, SLOW, 1};
        vecs[5]  = '{FUNCT_DIV,  32'h00000055, 32'd0,        5'd6,  32'hFFFFFFFF, 0,    0};
        vecs[6]  = '{FUNCT_REMU, 32'h00001234, 32'd0,        5'd7,  32'h00001234, 0,    0};
        vecs[7]  = '{FUNCT_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd8,  32'h80000000, 0,    0};
        vecs[8]  = '{FUNCT_REM,  32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h00000000, 0,    0};
        vecs[9]  = '{FUNCT_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h00000000, SLOW, 1};
        vecs[10] = '{FUNCT_REMU, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 0,    0};
        vecs[11] = '{FUNCT_DIV,  32'h80000000, 32'd0,        5'd12, 32'hFFFFFFFF, 0,    0};
        vecs[12] = '{FUNCT_REM,  32'd7,        32'hFFFFFFFD, 5'd13, 32'd1,        SLOW, 1};

        #2;
        check("rst out_valid", 32'(OUT_VALID), 32'd0);
        check("rst div_start", 32'(DIV_START), 32'd0);
        check("rst busy", 32'(BUSY), 32'd0);
        check("rst result", RESULT, 32'd0);
        check("rst tag_out", 32'(TAG_OUT), 32'd0);
        check("rst dividend", DIV_DIVIDEND, 32'd0);
        check("rst divider", DIV_DIVIDER, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].funct, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].tag, vecs[i].result, vecs[i].lat, vecs[i].starts, 0, 0, 0);
        end

        // Five stalled cycles while waiting on the core, three cycles of backpressure in DONE
        run_op("stall_bp", FUNCT_DIVU, 32'd1000, 32'd10, 5'd21, 32'd100, SLOW + 5, 1, 10, 5, 3);

        // Prime the cache with 9/3, then reset in the middle of another op
        run_op("prime", FUNCT_DIVU, 32'd9, 32'd3, 5'd22, 32'd3, SLOW, 1, 0, 0, 0);
        @(negedge CLK);
        IN_VALID = 1'b1;
        FUNCT    = FUNCT_DIVU;
        RS1      = 32'd100;
        RS2      = 32'd3;
        TAG_IN   = 5'd23;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        check("mid_op busy", 32'(BUSY), 32'd1);
        RST = 1'b1;
        #1;
        check("mid_rst out_valid", 32'(OUT_VALID), 32'd0);
        check("mid_rst div_start", 32'(DIV_START), 32'd0);
        check("mid_rst busy", 32'(BUSY), 32'd0);
        check("mid_rst result", RESULT, 32'd0);
        check("mid_rst tag_out", 32'(TAG_OUT), 32'd0);
        check("mid_rst dividend", DIV_DIVIDEND, 32'd0);
        check("mid_rst divider", DIV_DIVIDER, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Cache was cleared: 9/3 must go through the core again, then REMU hits
        run_op("post_rst_divu", FUNCT_DIVU, 32'd9, 32'd3, 5'd24, 32'd3, SLOW, 1, 0, 0, 0);
        run_op("post_rst_remu", FUNCT_REMU, 32'd9, 32'd3, 5'd25, 32'd0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
